// File: rtl/uart_frame_link.sv
// Frame link between a byte-wide UART and a frame-wide coprocessor: packs received
// characters into frames queued in a small FIFO, and serializes outgoing frames.
module uart_frame_link #(
    parameter int               DBITS       = 8,
    parameter int               FRAME_BYTES = 18,
    parameter int               FIFO_DEPTH  = 4,
    parameter int               TIMEOUT_CYC = 1_000_000,
    parameter int               PAD_EN      = 1,
    parameter logic [DBITS-1:0] PAD_CHAR    = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DBITS-1:0]                     rx_data,
    input  logic                                 rx_valid,
    output logic [FRAME_BYTES*DBITS-1:0]         din,
    output logic                                 din_valid,
    input  logic                                 din_ready,
    input  logic [FRAME_BYTES*DBITS-1:0]         dout,
    input  logic [$clog2(FRAME_BYTES+1)-1:0]     dout_len,
    input  logic                                 dout_valid,
    output logic                                 dout_ready,
    output logic [DBITS-1:0]                     tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      rx_level,
    output logic                                 rx_overflow,
    output logic                                 tx_busy
);

    localparam int FW   = FRAME_BYTES * DBITS;
    localparam int IDXW = $clog2(FRAME_BYTES);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int LVLW = $clog2(FIFO_DEPTH + 1);
    localparam int LENW = $clog2(FRAME_BYTES + 1);
    localparam int TOW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [IDXW-1:0] r_index;
    logic [TOW-1:0]  r_idle;
    logic [PTRW-1:0] r_wrPtr;
    logic [PTRW-1:0] r_rdPtr;
    logic [LVLW-1:0] r_level;
    logic            r_overflow;
    logic [FW-1:0]   r_frame;
    logic [FW-1:0]   r_mem [FIFO_DEPTH];

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_cnt;
    logic [LENW-1:0] r_len;
    logic [FW-1:0]   r_txFrame;

    logic            w_pop;
    logic            w_lastChar;
    logic            w_timeout;
    logic            w_write;
    logic            w_full;
    logic            w_push;
    logic [FW-1:0]   w_wrData;
    logic [LENW-1:0] w_effLen;
    logic [IDXW-1:0] w_cntNext;
    logic [DBITS-1:0] w_txChar;

    assign w_pop      = (r_level != '0) && din_ready;
    assign w_lastChar = rx_valid && (r_index == IDXW'(FRAME_BYTES - 1));
    assign w_timeout  = (TIMEOUT_CYC != 0) && !rx_valid && (r_index != '0) && (r_idle == TO_LAST);
    assign w_write    = w_lastChar || (w_timeout && (PAD_EN != 0));
    assign w_full     = (r_level == LVLW'(FIFO_DEPTH));
    assign w_push     = w_write && !w_full;

    // A completed frame takes the arriving character in the last slot; a timed-out
    // frame has every position from the current index upward replaced by the pad.
    always_comb begin
        w_wrData = r_frame;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (w_lastChar) begin
                if (IDXW'(k) == r_index) w_wrData[k*DBITS +: DBITS] = rx_data;
            end else if (IDXW'(k) >= r_index) begin
                w_wrData[k*DBITS +: DBITS] = PAD_CHAR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_index    <= '0;
            r_idle     <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (rx_valid) begin
                r_idle  <= '0;
                r_index <= w_lastChar ? '0 : r_index + IDXW'(1);
            end else if (w_timeout) begin
                r_idle  <= '0;
                r_index <= '0;
            end else if (r_index != '0) begin
                r_idle  <= r_idle + TOW'(1);
            end
            if (w_write && w_full) r_overflow <= 1'b1;
            if (w_push) r_wrPtr <= r_wrPtr + PTRW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTRW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVLW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVLW'(1);
        end
    end

    // Data storage carries no reset so frames survive reset and stay cheap.
    always_ff @(posedge clk) begin
        if (rx_valid) begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (IDXW'(k) == r_index) r_frame[k*DBITS +: DBITS] <= rx_data;
            end
        end
        if (w_push) r_mem[r_wrPtr] <= w_wrData;
        if ((r_state == S_IDLE) && dout_valid) r_txFrame <= dout;
    end

    assign din         = r_mem[r_rdPtr];
    assign din_valid   = (r_level != '0);
    assign rx_level    = r_level;
    assign rx_overflow = r_overflow;

    assign w_effLen  = ((dout_len == '0) || (dout_len > LENW'(FRAME_BYTES))) ? LENW'(FRAME_BYTES) : dout_len;
    assign w_cntNext = r_cnt + IDXW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dout_valid) begin
                        r_len   <= w_effLen;
                        r_cnt   <= '0;
                        r_state <= (w_effLen == LENW'(1)) ? S_LAST : S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_cnt <= w_cntNext;
                        if (LENW'(w_cntNext) == r_len - LENW'(1)) r_state <= S_LAST;
                    end
                end
                S_LAST: begin
                    if (tx_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_txChar = '0;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (r_cnt == IDXW'(k)) w_txChar = r_txFrame[k*DBITS +: DBITS];
        end
    end

    assign tx_valid   = (r_state == S_SEND) || (r_state == S_LAST);
    assign tx_data    = tx_valid ? w_txChar : '0;
    assign tx_busy    = (r_state != S_IDLE);
    assign dout_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_frame_link.sv
// Scoreboard bench for uart_frame_link: RX frames and TX characters are queued as
// they are driven and compared when the design presents them.
module tb_uart_frame_link;

    localparam int         FB    = 18;
    localparam int         DEPTH = 4;
    localparam int         TMO   = 20;
    localparam int         FW    = FB * 8;
    localparam logic [7:0] PAD   = 8'h5A;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rxData = '0;
    logic          rxValid = 1'b0;
    logic          npEn = 1'b0;
    logic          rxValidNp;
    logic [FW-1:0] din;
    logic          dinValid;
    logic          dinReady = 1'b0;
    logic [FW-1:0] dout = '0;
    logic [4:0]    doutLen = '0;
    logic          doutValid = 1'b0;
    logic          doutReady;
    logic [7:0]    txData;
    logic          txValid;
    logic          txReady = 1'b0;
    logic [2:0]    rxLevel;
    logic          rxOverflow;
    logic          txBusy;

    logic [FW-1:0] dinNp;
    logic          dinValidNp;
    logic          doutReadyNp;
    logic [7:0]    txDataNp;
    logic          txValidNp;
    logic [2:0]    rxLevelNp;
    logic          rxOverflowNp;
    logic          txBusyNp;

    int            compared = 0;
    int            mismatched = 0;
    logic [FW-1:0] rxExp[$];
    logic [7:0]    txExp[$];
    int            modelLevel = 0;
    bit            modelOvf = 1'b0;
    int            txHandshakes = 0;
    bit            prevStall = 1'b0;
    logic [7:0]    prevData = '0;

    assign rxValidNp = rxValid && npEn;

    always #5 clk = ~clk;

    uart_frame_link #(
        .DBITS(8), .FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO),
        .PAD_EN(1), .PAD_CHAR(PAD)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rxData), .rx_valid(rxValid),
        .din(din), .din_valid(dinValid), .din_ready(dinReady),
        .dout(dout), .dout_len(doutLen), .dout_valid(doutValid), .dout_ready(doutReady),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .rx_level(rxLevel), .rx_overflow(rxOverflow), .tx_busy(txBusy)
    );

    // Second instance with padding disabled, fed only during the timeout test.
    uart_frame_link #(
        .DBITS(8), .FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO),
        .PAD_EN(0), .PAD_CHAR(PAD)
    ) dutNp (
        .clk(clk), .rst(rst), .rx_data(rxData), .rx_valid(rxValidNp),
        .din(dinNp), .din_valid(dinValidNp), .din_ready(1'b0),
        .dout('0), .dout_len(5'd0), .dout_valid(1'b0), .dout_ready(doutReadyNp),
        .tx_data(txDataNp), .tx_valid(txValidNp), .tx_ready(1'b0),
        .rx_level(rxLevelNp), .rx_overflow(rxOverflowNp), .tx_busy(txBusyNp)
    );

    task automatic checkOutput(input string tag, input logic [FW-1:0] observed, input logic [FW-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Every TX handshake is checked against the queue; stalls must hold tx_data.
    always @(negedge clk) begin
        if (!rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) checkOutput("txStable", FW'(txData), FW'(prevData));
            if (txValid && txReady) begin
                txHandshakes++;
                if (txExp.size() == 0) checkOutput("txUnexpected", FW'(txExp.size()), FW'(1));
                else checkOutput("txChar", FW'(txData), FW'(txExp.pop_front()));
            end
            prevStall = txValid && !txReady;
            prevData  = txData;
        end
    end

    task automatic rxChar(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] first);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < FB; i++) begin
            f[i*8 +: 8] = first + 8'(i);
            rxChar(first + 8'(i));
        end
        if (modelLevel < DEPTH) begin
            rxExp.push_back(f);
            modelLevel++;
        end else begin
            modelOvf = 1'b1;
        end
    endtask

    task automatic popFrame(input string tag);
        int n;
        n = 0;
        while (!dinValid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        if (!dinValid) begin
            checkOutput({tag, "Valid"}, FW'(dinValid), FW'(1));
        end else begin
            if (rxExp.size() == 0) checkOutput({tag, "Queue"}, FW'(rxExp.size()), FW'(1));
            else checkOutput(tag, din, rxExp.pop_front());
            dinReady = 1'b1;
            @(posedge clk); #1;
            dinReady = 1'b0;
            modelLevel--;
        end
    endtask

    task automatic sendTx(input logic [FW-1:0] data, input int len, input bit toggle);
        int eff;
        int n;
        eff = (len == 0 || len > FB) ? FB : len;
        for (int i = 0; i < eff; i++) txExp.push_back(data[i*8 +: 8]);
        txHandshakes = 0;
        dout      = data;
        doutLen   = 5'(len);
        doutValid = 1'b1;
        txReady   = 1'b0;
        @(posedge clk); #1;
        doutValid = 1'b0;
        @(negedge clk);
        checkOutput("txBusy", FW'(txBusy), FW'(1));
        checkOutput("doutReadyBusy", FW'(doutReady), FW'(0));
        n = 0;
        while (txBusy && n < 200) begin
            @(posedge clk); #1;
            txReady = toggle ? !txReady : 1'b1;
            n++;
        end
        @(negedge clk);
        checkOutput("txHandshakes", FW'(txHandshakes), FW'(eff));
        checkOutput("doutReadyIdle", FW'(doutReady), FW'(1));
        checkOutput("txLeftover", FW'(txExp.size()), FW'(0));
        txReady = 1'b0;
        txExp.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "DinValid"}, FW'(dinValid), FW'(0));
        checkOutput({tag, "TxValid"}, FW'(txValid), FW'(0));
        checkOutput({tag, "TxBusy"}, FW'(txBusy), FW'(0));
        checkOutput({tag, "DoutReady"}, FW'(doutReady), FW'(1));
        checkOutput({tag, "TxData"}, FW'(txData), FW'(0));
        checkOutput({tag, "RxLevel"}, FW'(rxLevel), FW'(0));
        checkOutput({tag, "Overflow"}, FW'(rxOverflow), FW'(0));
    endtask

    function automatic logic [FW-1:0] randFrame();
        logic [FW-1:0] f;
        for (int i = 0; i < FB; i++) f[i*8 +: 8] = 8'($urandom_range(0, 255));
        return f;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [FW-1:0] f;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst0");
        checkOutput("rst0NpLevel", FW'(rxLevelNp), FW'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single frame, latency and packing");
        applyStimulus(8'h01);
        @(negedge clk);
        checkOutput("f1DinValid", FW'(dinValid), FW'(1));
        checkOutput("f1Byte0", FW'(din[7:0]), FW'(8'h01));
        checkOutput("f1Byte17", FW'(din[143:136]), FW'(8'h12));
        checkOutput("f1Level", FW'(rxLevel), FW'(1));
        popFrame("f1Frame");

        $display("[TB] five frames into a four-deep FIFO");
        for (int f5 = 0; f5 < 5; f5++) applyStimulus(8'(8'h20 * (f5 + 1)));
        @(negedge clk);
        checkOutput("ovfLevel", FW'(rxLevel), FW'(DEPTH));
        checkOutput("ovfFlag", FW'(rxOverflow), FW'(modelOvf));
        for (int p = 0; p < DEPTH; p++) popFrame("ovfFrame");
        @(negedge clk);
        checkOutput("ovfDrained", FW'(rxLevel), FW'(0));

        $display("[TB] partial frame timeout, pad and discard");
        npEn = 1'b1;
        rxChar(8'hA1);
        rxChar(8'hA2);
        rxChar(8'hA3);
        npEn = 1'b0;
        f = '0;
        f[7:0] = 8'hA1;
        f[15:8] = 8'hA2;
        f[23:16] = 8'hA3;
        for (int i = 3; i < FB; i++) f[i*8 +: 8] = PAD;
        rxExp.push_back(f);
        modelLevel++;
        n = 0;
        while (!dinValid && n < TMO + 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeoutCycles", FW'(n), FW'(TMO));
        popFrame("padFrame");
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("npLevel", FW'(rxLevelNp), FW'(0));
        checkOutput("npOverflow", FW'(rxOverflowNp), FW'(0));

        $display("[TB] TX serializer");
        sendTx(randFrame(), 4, 1'b1);
        sendTx(randFrame(), 0, 1'b0);
        sendTx(randFrame(), 1, 1'b1);
        sendTx(randFrame(), 20, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 9; i++) rxChar(8'(8'hC0 + i));
        f = randFrame();
        for (int i = 0; i < FB; i++) txExp.push_back(f[i*8 +: 8]);
        dout      = f;
        doutLen   = 5'd0;
        doutValid = 1'b1;
        txReady   = 1'b1;
        @(posedge clk); #1;
        doutValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("rst1");
        txExp.delete();
        modelLevel = 0;
        modelOvf   = 1'b0;
        @(posedge clk); #1;
        txReady = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'h61);
        popFrame("postRstFrame");
        sendTx(randFrame(), 2, 1'b1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_frame_link.md
UART_FRAME_LINK -- requirements
Module: uart_frame_link

Interface
REQ-001 SHALL have parameter DBITS, default 8, bits per UART character.
REQ-002 SHALL have parameter FRAME_BYTES, default 18, characters per frame (range 2..64).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, RX frame FIFO depth in frames (power of two, range 2..16).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1_000_000, idle cycles before a partial RX frame is resolved; 0 disables timeout.
REQ-005 SHALL have parameter PAD_EN, default 1: 1 = pad partial frame on timeout, 0 = discard it.
REQ-006 SHALL have parameter PAD_CHAR, default 8'h00, DBITS wide, fill value for padded positions.
REQ-007 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port rx_data, input, DBITS, received character from the UART receiver.
REQ-010 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-011 SHALL have port din, output, FRAME_BYTES*DBITS, head RX frame to the coprocessor.
REQ-012 SHALL have ports din_valid (output, 1) and din_ready (input, 1), RX frame handshake.
REQ-013 SHALL have port dout, input, FRAME_BYTES*DBITS, frame from the coprocessor.
REQ-014 SHALL have port dout_len, input, $clog2(FRAME_BYTES+1), characters to send; 0 or >FRAME_BYTES means FRAME_BYTES.
REQ-015 SHALL have ports dout_valid (input, 1) and dout_ready (output, 1), TX frame handshake.
REQ-016 SHALL have ports tx_data (output, DBITS), tx_valid (output, 1) and tx_ready (input, 1), character stream to the UART transmitter.
REQ-017 SHALL have port rx_level, output, $clog2(FIFO_DEPTH+1), frames held in the RX FIFO.
REQ-018 SHALL have port rx_overflow, output, 1, sticky flag, set on any dropped frame.
REQ-019 SHALL have port tx_busy, output, 1, high while the TX serializer is not IDLE.

Function
REQ-020 SHALL pack characters little-endian: character k of a frame occupies bits [DBITS*(k+1)-1 : DBITS*k], with character 0 received first.
REQ-021 SHALL keep a character index 0..FRAME_BYTES-1 and increment it on each rx_valid.
REQ-022 SHALL, on rx_valid with index == FRAME_BYTES-1, write the completed frame to the FIFO at that same edge and reset the index to 0; din_valid SHALL be high from the next cycle if the FIFO was empty (latency 1).
REQ-023 SHALL, if the FIFO is full at the write edge, drop the frame, set rx_overflow, reset the index to 0 and leave FIFO contents unchanged; a simultaneous pop does not rescue the write.
REQ-024 SHALL drive din with the FIFO head (show-ahead) and din_valid = (rx_level != 0); a pop occurs when din_valid && din_ready.
REQ-025 SHALL update rx_level by +1 on write only, -1 on pop only, and leave it unchanged on a simultaneous write and pop.
REQ-026 SHALL maintain an idle counter that clears on rx_valid and counts only while index > 0.
REQ-027 SHALL, when the idle counter reaches TIMEOUT_CYC with no rx_valid in that cycle: if PAD_EN=1, fill positions index..FRAME_BYTES-1 with PAD_CHAR and write the frame under the REQ-023 rules; if PAD_EN=0, discard the partial frame; in both cases reset the index to 0.
REQ-028 SHALL give rx_valid priority over timeout in the same cycle.
REQ-029 SHALL implement the TX FSM with states IDLE, SEND and LAST.
REQ-030 SHALL drive dout_ready = 1 only in IDLE.
REQ-031 SHALL, on dout_valid in IDLE, latch dout and the effective length L, set the character counter c = 0, and go to SEND, or to LAST when L == 1.
REQ-032 SHALL hold tx_valid high in SEND and LAST, with tx_data = character c of the latched frame.
REQ-033 SHALL advance c on tx_valid && tx_ready; in SEND, go to LAST when c becomes L-1; in LAST, go to IDLE.
REQ-034 SHALL keep tx_data stable while tx_valid && !tx_ready.
REQ-035 SHALL drive tx_busy = (state != IDLE).
REQ-036 SHALL run the RX and TX paths independently and concurrently.

Reset
REQ-037 SHALL, while rst is low, asynchronously clear the index, idle counter, FIFO pointers, rx_level, rx_overflow, c and the latched TX length, and force the FSM to IDLE.
REQ-038 SHALL, while rst is low, force din_valid=0, tx_valid=0, tx_busy=0, dout_ready=1 and tx_data=0.
REQ-039 SHALL discard any partial RX frame or in-flight TX frame when reset is asserted mid-operation.
REQ-040 SHALL NOT clear FIFO storage contents on reset.

Verification
REQ-041 SHALL cover: 18 characters 8'h01..8'h12 with din_ready=0 -> din_valid=1 one cycle after the last strobe, din[7:0]=8'h01, din[143:136]=8'h12, rx_level=1.
REQ-042 SHALL cover: 5 frames with din_ready=0 and FIFO_DEPTH=4 -> rx_level=4, rx_overflow=1, and popping yields frames 1..4 intact.
REQ-043 SHALL cover: 3 characters then TIMEOUT_CYC idle cycles with PAD_EN=1 -> one frame with bytes 0..2 as sent and bytes 3..17 = PAD_CHAR; repeated with PAD_EN=0 -> rx_level stays 0.
REQ-044 SHALL cover: dout_len=4 with tx_ready toggling every cycle -> exactly 4 tx handshakes carrying dout bytes 0..3 in order, tx_data stable while stalled, then dout_ready=1.
REQ-045 SHALL cover: rst pulled low after 9 RX characters and during a TX frame -> all outputs at reset values; a fresh 18-character frame afterward is packed from index 0.
